// File: rtl/serial_frame_arbiter.sv
// ============================================================================
//  Module   : serial_frame_arbiter
//  Purpose  : Round-robin sharing of one serial Mealy engine among NREQ
//             requesters, one fixed-length frame per grant.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_frame_arbiter #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 3,
    parameter int ID_W      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_req_bit,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_bit_take,
    output logic            o_eng_clr,
    output logic            o_eng_en,
    output logic            o_eng_in,
    input  logic            i_eng_out,
    output logic            o_res_valid,
    output logic            o_res_bit,
    output logic [ID_W-1:0] o_res_id,
    output logic            o_done,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [ID_W-1:0]  C_ID_MAX = ID_W'(NREQ - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_gnt;
    logic [ID_W-1:0]   r_res_id;
    logic [ID_W-1:0]   r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_res_valid;

    logic              w_found;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_sel;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic              w_stream;

    // First set request at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found   = 1'b0;
        w_idx     = '0;
        w_sel     = '0;
        w_gnt_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = ID_W'((int'(r_ptr) + i) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        w_gnt_nxt[w_sel] = w_found;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stream    = 1'b0;
        o_eng_clr   = 1'b0;
        o_eng_en    = 1'b0;
        o_bit_take  = 1'b0;
        o_done      = 1'b0;
        o_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (|i_req) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                o_eng_clr   = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                w_stream   = 1'b1;
                o_eng_en   = 1'b1;
                o_bit_take = 1'b1;
                if (r_cnt == C_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt       <= '0;
            r_res_id    <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            // Engine output is registered, so each result trails its enable by one cycle.
            r_res_valid <= w_stream;
            unique case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_gnt    <= w_gnt_nxt;
                        r_res_id <= w_sel;
                    end
                end
                S_CLEAR: r_cnt <= '0;
                S_STREAM: begin
                    if (r_cnt != C_LAST) r_cnt <= r_cnt + 1'b1;
                end
                S_DRAIN: begin
                    r_gnt <= '0;
                    r_ptr <= (r_res_id == C_ID_MAX) ? '0 : r_res_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_res_id    = r_res_id;
    assign o_res_valid = r_res_valid;
    assign o_res_bit   = r_res_valid & i_eng_out;
    assign o_eng_in    = w_stream & i_req_bit[r_res_id];

endmodule

`default_nettype wire

// File: doc/serial_frame_arbiter.md
Name: serial_frame_arbiter

Overview:
- Shares one single-bit serial Mealy processing engine (1-bit state, registered output, sticky state) among NREQ serial requesters.
- Grants one requester at a time, round-robin, for a fixed frame of FRAME_LEN bits.
- Clears the engine state before every frame, so frames never inherit sticky state from a previous owner.
- Returns the engine's per-bit results to the granted requester, tagged with its ID.

Parameters:
- NREQ, 4, number of requesters (2..8)
- FRAME_LEN, 8, bits per granted frame (>=2)
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= FRAME_LEN
- ID_W, 2, requester-ID width; must satisfy 2**ID_W >= NREQ

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester frame request; level
- req_bit  in  NREQ  per-requester serial data bit
- gnt  out  NREQ  one-hot grant; held for the whole frame
- bit_take  out  1  granted requester advances to its next bit after this edge
- eng_clr  out  1  forces engine state to s0, output 0
- eng_en  out  1  engine samples eng_in this cycle
- eng_in  out  1  data bit to engine
- eng_out  in  1  engine registered output
- res_valid  out  1  res_bit/res_id valid this cycle
- res_bit  out  1  processed bit
- res_id  out  ID_W  index of the granted requester
- done  out  1  one-cycle pulse on the last result of a frame
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; gnt=0; counter=0; priority pointer=0 (req[0] has highest priority first).
  - All outputs 0, including eng_clr, eng_en, res_valid and done.
  - Reset mid-frame abandons the frame: no done pulse, no further res_valid.
- FSM states: IDLE, CLEAR, STREAM, DRAIN. All outputs except eng_in are registered or decoded from state.
- IDLE:
  - req is sampled only here.
  - If req != 0, select the first set bit searching upward from ptr, wrapping modulo NREQ.
  - Register gnt (one-hot) and res_id; next state CLEAR.
  - If req == 0, stay in IDLE.
- CLEAR (1 cycle):
  - eng_clr=1, eng_en=0, cnt cleared to 0.
  - Next state STREAM.
- STREAM (FRAME_LEN cycles):
  - eng_en=1 and bit_take=1.
  - eng_in = req_bit[res_id], combinational mux from the granted bit.
  - cnt increments each cycle.
  - When cnt == FRAME_LEN-1, next state DRAIN.
- Result timing:
  - res_valid is eng_en delayed by one cycle.
  - res_bit = eng_out in that cycle.
  - Latency from eng_in to its result: exactly 1 cycle.
  - Exactly FRAME_LEN res_valid pulses per frame, contiguous: first one in the 2nd STREAM cycle, last one in DRAIN.
- DRAIN (1 cycle):
  - Final res_valid=1 and done=1.
  - ptr updated to (granted index + 1) mod NREQ.
  - gnt cleared at the end of DRAIN; next state IDLE.
- Frame spacing: back-to-back frames cost FRAME_LEN+3 cycles each (IDLE, CLEAR, STREAM x FRAME_LEN, DRAIN).
- busy is high in CLEAR, STREAM and DRAIN.
- Boundary conditions:
  - req deasserted mid-frame: ignored; the frame completes.
  - Simultaneous requests: resolved purely by the round-robin pointer; no starvation. Each requester waits at most NREQ-1 frames.
  - Requester re-asserting immediately after its own frame is served after the other pending requesters.
  - eng_clr and eng_en are never high in the same cycle.
  - The counter wraps only via CLEAR, never mid-frame.

Test Plan:
- Reset, then req=4'b0001, req_bit[0] stream 0,0,1,0,0,1,1,0 (engine behaviour: s0 passes bits until the first 1, then outputs 1 for in=0 and 0 for in=1):
  - gnt=0001 for 10 cycles; eng_clr pulses once.
  - res_bit sequence 0,0,1,1,1,0,0,1 with res_id=0.
  - done coincides with the 8th res_valid.
- req=4'b1111 held constant for 4 frames: grant order 0,1,2,3, then 0; frame spacing 11 cycles.
- Requester 2 sends 1,1,... (engine ends in s1), then requester 3 sends all zeros:
  - requester 3 receives eight 0s, proving eng_clr cleared the sticky state.
- req[1] dropped in cycle 3 of STREAM: frame still yields 8 results and a done pulse; gnt held until DRAIN.
- rst_n pulsed low mid-STREAM (asynchronous, between edges):
  - outputs go to 0 immediately; no done pulse.
  - Next grant goes to the lowest set req bit starting from 0.
- req=0 for 20 cycles: busy=0, eng_en=0, res_valid=0 throughout.
